// File: rtl/tri_shade_fb_writer_if.sv
// Pixel-in / frame-buffer-out bundle for tri_shade_fb_writer.
// slave = the shader block, master = upstream + frame buffer side.
`timescale 1ns/1ps
interface tri_shade_fb_writer_if;
  logic         valid_pix_i;
  logic         ready_pix_o;
  logic [298:0] pix_data_i;
  logic         fb_ready_i;
  logic         fb_we_o;
  logic [16:0]  fb_addr_o;
  logic [15:0]  fb_data_o;

  modport slave (
    input  valid_pix_i,
    input  pix_data_i,
    input  fb_ready_i,
    output ready_pix_o,
    output fb_we_o,
    output fb_addr_o,
    output fb_data_o
  );

  modport master (
    output valid_pix_i,
    output pix_data_i,
    output fb_ready_i,
    input  ready_pix_o,
    input  fb_we_o,
    input  fb_addr_o,
    input  fb_data_o
  );
endinterface

// File: rtl/tri_shade_fb_writer.sv
// Gouraud shading to RGB565 with a frame-buffer write port.
// Three-stage pixel pipe; a clear FSM takes over the port when asked.
`timescale 1ns/1ps
module tri_shade_fb_writer #(
  parameter int          H_RES       = 320,
  parameter int          V_RES       = 240,
  parameter int          FRAC_BITS   = 20,
  parameter logic [15:0] CLEAR_COLOR = 16'h0000
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 fb_clear_i,
  output logic                 clear_busy_o,
  output logic [16:0]          pix_count_o,
  tri_shade_fb_writer_if.slave bus
);

  localparam int FB_DEPTH = H_RES * V_RES;
  localparam logic [16:0] LP_LAST = 17'(FB_DEPTH - 1);
  localparam logic [16:0] LP_SAT  = 17'(FB_DEPTH);
  localparam logic [9:0]  LP_HX   = 10'(H_RES);
  localparam logic [8:0]  LP_VY   = 9'(V_RES);
  localparam logic signed [31:0] LP_RND =
    32'sd1 <<< (FRAC_BITS - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_clr_pend;
  logic [16:0] r_clr_addr;
  logic [16:0] r_count;

  logic            r_s1_vld;
  logic            r_s1_oor;
  logic [8:0]      r_s1_x;
  logic [7:0]      r_s1_y;
  logic [2:0][7:0] r_s1_c0;
  logic [2:0][8:0] r_s1_d10;
  logic [2:0][8:0] r_s1_d20;
  logic [20:0]     r_s1_ub;
  logic [20:0]     r_s1_vb;

  logic             r_s2_vld;
  logic             r_s2_oor;
  logic [16:0]      r_s2_addr;
  logic [2:0][31:0] r_s2_c0s;
  logic [2:0][29:0] r_s2_p10;
  logic [2:0][29:0] r_s2_p20;

  logic        r_s3_vld;
  logic        r_s3_oor;
  logic [16:0] r_s3_addr;
  logic [15:0] r_s3_data;

  logic             w_stall;
  logic             w_ready;
  logic             w_xfer;
  logic             w_pipe_busy;
  logic             w_pix_done;
  logic             w_oor;
  logic [8:0]       w_x;
  logic [7:0]       w_y;
  logic [20:0]      w_ub;
  logic [20:0]      w_vb;
  logic [16:0]      w_addr;
  logic [2:0][7:0]  w_c0;
  logic [2:0][7:0]  w_c1;
  logic [2:0][7:0]  w_c2;
  logic [2:0][8:0]  w_d10;
  logic [2:0][8:0]  w_d20;
  logic [2:0][29:0] w_p10;
  logic [2:0][29:0] w_p20;
  logic [2:0][31:0] w_c0s;
  logic [2:0][7:0]  w_ch;
  logic [15:0]      w_rgb;
  logic             w_unused;

  assign w_x  = bus.pix_data_i[298:290];
  assign w_y  = bus.pix_data_i[289:282];
  assign w_ub = bus.pix_data_i[41:21];
  assign w_vb = bus.pix_data_i[20:0];

  assign w_oor = ({1'b0, w_x} >= LP_HX)
              || ({1'b0, w_y} >= LP_VY);

  assign w_addr = 17'(r_s1_y) * 17'(H_RES)
                + 17'(r_s1_x);

  // channel k: 0=R 1=G 2=B
  for (genvar k = 0; k < 3; k++) begin : g_ch
    logic signed [31:0] w_sum;
    logic signed [31:0] w_sh;

    assign w_c0[k] = bus.pix_data_i[105-8*k -: 8];
    assign w_c1[k] = bus.pix_data_i[185-8*k -: 8];
    assign w_c2[k] = bus.pix_data_i[265-8*k -: 8];

    assign w_d10[k] = {1'b0, w_c1[k]}
                    - {1'b0, w_c0[k]};
    assign w_d20[k] = {1'b0, w_c2[k]}
                    - {1'b0, w_c0[k]};

    assign w_p10[k] =
      $signed({{9{r_s1_ub[20]}}, r_s1_ub})
      * $signed({{21{r_s1_d10[k][8]}}, r_s1_d10[k]});
    assign w_p20[k] =
      $signed({{9{r_s1_vb[20]}}, r_s1_vb})
      * $signed({{21{r_s1_d20[k][8]}}, r_s1_d20[k]});

    assign w_c0s[k] = 32'(r_s1_c0[k]) << FRAC_BITS;

    assign w_sum =
      $signed(r_s2_c0s[k])
      + $signed({{2{r_s2_p10[k][29]}}, r_s2_p10[k]})
      + $signed({{2{r_s2_p20[k][29]}}, r_s2_p20[k]})
      + LP_RND;

    assign w_sh = w_sum >>> FRAC_BITS;

    assign w_ch[k] = w_sh[31]           ? 8'd0  :
                     (w_sh > 32'sd255)  ? 8'hFF :
                                          w_sh[7:0];
  end

  assign w_rgb = {w_ch[0][7:3],
                  w_ch[1][7:2],
                  w_ch[2][7:3]};

  assign w_unused = ^{bus.pix_data_i[281:266],
                      bus.pix_data_i[241:186],
                      bus.pix_data_i[161:106],
                      bus.pix_data_i[81:42],
                      w_ch[0][2:0],
                      w_ch[1][1:0],
                      w_ch[2][2:0]};

  assign w_stall     = r_s3_vld && !bus.fb_ready_i;
  assign w_pipe_busy = r_s1_vld || r_s2_vld || r_s3_vld;
  assign w_pix_done  = r_s3_vld && !r_s3_oor
                    && bus.fb_ready_i;

  assign w_ready = reset_n_i
                && (r_state == ST_RUN)
                && !r_clr_pend
                && !w_stall;
  assign w_xfer  = bus.valid_pix_i && w_ready;

  assign bus.ready_pix_o = w_ready;
  assign bus.fb_we_o     = (r_state == ST_CLEAR)
                        || (r_s3_vld && !r_s3_oor);
  assign bus.fb_addr_o   = (r_state == ST_CLEAR)
                        ? r_clr_addr : r_s3_addr;
  assign bus.fb_data_o   = (r_state == ST_CLEAR)
                        ? CLEAR_COLOR : r_s3_data;
  assign clear_busy_o    = r_clr_pend;
  assign pix_count_o     = r_count;

  // every stage freezes, bubbles included, while S3 waits on the FB
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_s1_vld  <= 1'b0;
      r_s1_oor  <= 1'b0;
      r_s1_x    <= '0;
      r_s1_y    <= '0;
      r_s1_c0   <= '0;
      r_s1_d10  <= '0;
      r_s1_d20  <= '0;
      r_s1_ub   <= '0;
      r_s1_vb   <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_oor  <= 1'b0;
      r_s2_addr <= '0;
      r_s2_c0s  <= '0;
      r_s2_p10  <= '0;
      r_s2_p20  <= '0;
      r_s3_vld  <= 1'b0;
      r_s3_oor  <= 1'b0;
      r_s3_addr <= '0;
      r_s3_data <= '0;
    end else if (!w_stall) begin
      r_s1_vld <= w_xfer;
      if (w_xfer) begin
        r_s1_oor <= w_oor;
        r_s1_x   <= w_x;
        r_s1_y   <= w_y;
        r_s1_c0  <= w_c0;
        r_s1_d10 <= w_d10;
        r_s1_d20 <= w_d20;
        r_s1_ub  <= w_ub;
        r_s1_vb  <= w_vb;
      end
      r_s2_vld  <= r_s1_vld;
      r_s2_oor  <= r_s1_oor;
      r_s2_addr <= w_addr;
      r_s2_c0s  <= w_c0s;
      r_s2_p10  <= w_p10;
      r_s2_p20  <= w_p20;
      r_s3_vld  <= r_s2_vld;
      r_s3_oor  <= r_s2_oor;
      r_s3_addr <= r_s2_addr;
      r_s3_data <= w_rgb;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= ST_RUN;
      r_clr_pend <= 1'b0;
      r_clr_addr <= '0;
      r_count    <= '0;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (w_pix_done && r_count != LP_SAT)
            r_count <= r_count + 17'd1;
          if (fb_clear_i) begin
            r_clr_pend <= 1'b1;
            if (w_pipe_busy || w_xfer) begin
              r_state <= ST_DRAIN;
            end else begin
              r_state <= ST_CLEAR;
              r_count <= '0;
            end
          end
        end
        ST_DRAIN: begin
          if (w_pix_done && r_count != LP_SAT)
            r_count <= r_count + 17'd1;
          if (!w_pipe_busy) begin
            r_state <= ST_CLEAR;
            r_count <= '0;
          end
        end
        ST_CLEAR: begin
          r_count <= '0;
          if (bus.fb_ready_i) begin
            if (r_clr_addr == LP_LAST) begin
              r_state    <= ST_RUN;
              r_clr_pend <= 1'b0;
              r_clr_addr <= '0;
            end else begin
              r_clr_addr <= r_clr_addr + 17'd1;
            end
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

endmodule
